// File: rtl/retrocomm_arbiter_if.sv
// Requester and RetroComm link signal bundle for retrocomm_arbiter.
// master = arbiter side, slave = requesters plus link target.
interface retrocomm_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      Req;
    logic [16*NREQ-1:0]   ReqData;
    logic [NREQ-1:0]      ReqAck;
    logic [NREQ-1:0]      RspValid;
    logic [15:0]          RspData;
    logic                 RspErr;
    logic                 Busy;
    logic [15:0]          LinkDout;
    logic                 LinkRaise;
    logic [15:0]          LinkDin;
    logic                 LinkStrobe;
    logic                 LinkInterrupt;
    logic                 IrqPending;
    logic                 IrqClear;

    modport master (
        input  Req, ReqData, LinkDin, LinkStrobe, LinkInterrupt, IrqClear,
        output ReqAck, RspValid, RspData, RspErr, Busy, LinkDout, LinkRaise, IrqPending
    );

    modport slave (
        output Req, ReqData, LinkDin, LinkStrobe, LinkInterrupt, IrqClear,
        input  ReqAck, RspValid, RspData, RspErr, Busy, LinkDout, LinkRaise, IrqPending
    );
endinterface

// File: rtl/retrocomm_arbiter.sv
// Round-robin initiator sharing one RetroComm link among NREQ requesters.
// Optional target-response timeout enabled by macro RETROCOMM_ARB_TIMEOUT_EN.
module retrocomm_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                Clk,
    input  logic                Reset,
    retrocomm_arbiter_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("retrocomm_arbiter: NREQ out of range");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("retrocomm_arbiter: TIMEOUT out of range");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0] req_ack_q, req_ack_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0]     rsp_data_q, rsp_data_d;
    logic [15:0]     link_dout_q, link_dout_d;
    logic            link_raise_q, link_raise_d;
    logic            busy_q, busy_d;
    logic            irq_pend_q, irq_pend_d;
    logic            int_prev_q, int_prev_d;
`ifdef RETROCOMM_ARB_TIMEOUT_EN
    logic            rsp_err_q, rsp_err_d;
    logic [15:0]     tmo_cnt_q, tmo_cnt_d;
`endif

    logic [PW-1:0]   pick_s;
    logic            found_s;
    int              idx_s;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx_s = (int'(ptr_q) + off) % NREQ;
            if (!found_s && bus.Req[idx_s]) begin
                found_s = 1'b1;
                pick_s  = PW'(idx_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        req_ack_d    = '0;
        rsp_valid_d  = '0;
        rsp_data_d   = rsp_data_q;
        link_dout_d  = link_dout_q;
        link_raise_d = 1'b0;
`ifdef RETROCOMM_ARB_TIMEOUT_EN
        rsp_err_d    = rsp_err_q;
        tmo_cnt_d    = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    // Outputs for the ISSUE cycle are registered on entry to it
                    gnt_d             = pick_s;
                    ptr_d             = pick_s;
                    link_dout_d       = bus.ReqData[16*int'(pick_s) +: 16];
                    link_raise_d      = 1'b1;
                    req_ack_d[pick_s] = 1'b1;
                    state_d           = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
`ifdef RETROCOMM_ARB_TIMEOUT_EN
                tmo_cnt_d = 16'(TIMEOUT);
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.LinkStrobe) begin
                    rsp_data_d         = bus.LinkDin;
                    rsp_valid_d[gnt_q] = 1'b1;
`ifdef RETROCOMM_ARB_TIMEOUT_EN
                    rsp_err_d          = 1'b0;
`endif
                    state_d            = RESP;
                end
`ifdef RETROCOMM_ARB_TIMEOUT_EN
                // Expiry falls on the TIMEOUT-th WAIT cycle after ISSUE
                else if (tmo_cnt_q <= 16'd1) begin
                    rsp_data_d         = 16'hFFFF;
                    rsp_err_d          = 1'b1;
                    rsp_valid_d[gnt_q] = 1'b1;
                    tmo_cnt_d          = 16'd0;
                    state_d            = RESP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - 16'd1;
                    state_d   = WAIT;
                end
`else
                else begin
                    state_d = WAIT;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);

        // Rising-edge set takes priority over a simultaneous clear
        int_prev_d = bus.LinkInterrupt;
        if (bus.LinkInterrupt && !int_prev_q) begin
            irq_pend_d = 1'b1;
        end else if (bus.IrqClear) begin
            irq_pend_d = 1'b0;
        end else begin
            irq_pend_d = irq_pend_q;
        end
    end

    // State and output registers, synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            ptr_q        <= PW'(NREQ - 1);
            gnt_q        <= '0;
            req_ack_q    <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= 16'h0000;
            link_dout_q  <= 16'h0000;
            link_raise_q <= 1'b0;
            busy_q       <= 1'b0;
            irq_pend_q   <= 1'b0;
            int_prev_q   <= 1'b0;
`ifdef RETROCOMM_ARB_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
            tmo_cnt_q    <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            req_ack_q    <= req_ack_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            link_dout_q  <= link_dout_d;
            link_raise_q <= link_raise_d;
            busy_q       <= busy_d;
            irq_pend_q   <= irq_pend_d;
            int_prev_q   <= int_prev_d;
`ifdef RETROCOMM_ARB_TIMEOUT_EN
            rsp_err_q    <= rsp_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
`endif
        end
    end

    assign bus.ReqAck     = req_ack_q;
    assign bus.RspValid   = rsp_valid_q;
    assign bus.RspData    = rsp_data_q;
    assign bus.Busy       = busy_q;
    assign bus.LinkDout   = link_dout_q;
    assign bus.LinkRaise  = link_raise_q;
    assign bus.IrqPending = irq_pend_q;
`ifdef RETROCOMM_ARB_TIMEOUT_EN
    assign bus.RspErr     = rsp_err_q;
`else
    assign bus.RspErr     = 1'b0;
`endif
endmodule

// File: tb/tb_retrocomm_arbiter.sv
// Scoreboard bench for retrocomm_arbiter: expected issues/responses queued at
// stimulus time, checked when the DUT raises LinkRaise / RspValid.
module tb_retrocomm_arbiter;
    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    retrocomm_arbiter_if #(.NREQ(NREQ)) bus ();
    retrocomm_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct packed { logic [3:0] idx; logic [15:0] cmd; } iss_t;
    typedef struct packed { logic [3:0] idx; logic [15:0] data; logic err; } rsp_t;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    iss_t mi;
    rsp_t mr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int issue_cnt = 0;
    int last_raise = -1;
    bit chk_spacing = 1'b0;
    logic [15:0] last_data = 16'h0000;

    bit tgt_en = 1'b0;
    bit tgt_fixed = 1'b0;
    logic [15:0] tgt_val = 16'h0000;
    int tgt_delay = 0;
    logic [15:0] tgt_cmd;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push_iss(input logic [3:0] idx, input logic [15:0] cmd);
        exp_iss.push_back('{idx: idx, cmd: cmd});
    endtask

    task automatic push_rsp(input logic [3:0] idx, input logic [15:0] data, input logic err);
        exp_rsp.push_back('{idx: idx, data: data, err: err});
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge Clk) begin
        if (bus.LinkRaise) begin
            if (exp_iss.size() == 0) begin
                check_eq("unexpected_issue", 32'd1, 32'd0);
            end else begin
                mi = exp_iss.pop_front();
                check_eq("iss_ack", 32'(bus.ReqAck), 32'd1 << mi.idx);
                check_eq("iss_dout", 32'(bus.LinkDout), 32'(mi.cmd));
            end
            if (chk_spacing && last_raise >= 0) check_eq("spacing", cyc - last_raise, 32'd4);
            last_raise = cyc;
            issue_cnt++;
        end else if (bus.ReqAck != 4'b0000) begin
            check_eq("stray_ack", 32'(bus.ReqAck), 32'd0);
        end
        if (bus.RspValid != 4'b0000) begin
            if (exp_rsp.size() == 0) begin
                check_eq("unexpected_rsp", 32'(bus.RspValid), 32'd0);
            end else begin
                mr = exp_rsp.pop_front();
                check_eq("rsp_valid", 32'(bus.RspValid), 32'd1 << mr.idx);
                check_eq("rsp_data", 32'(bus.RspData), 32'(mr.data));
                check_eq("rsp_err", 32'(bus.RspErr), 32'(mr.err));
                last_data = mr.data;
            end
        end
    end

    // Link target model: strobes tgt_delay WAIT cycles after the first WAIT cycle
    initial begin
        bus.LinkStrobe = 1'b0;
        bus.LinkDin    = 16'h0000;
        forever begin
            @(negedge Clk);
            if (tgt_en && bus.LinkRaise) begin
                tgt_cmd = bus.LinkDout;
                @(negedge Clk);
                repeat (tgt_delay) @(negedge Clk);
                bus.LinkDin    = tgt_fixed ? tgt_val : {12'h000, tgt_cmd[3:0]};
                bus.LinkStrobe = 1'b1;
                @(negedge Clk);
                bus.LinkStrobe = 1'b0;
                check_eq("rsp_lat", 32'(bus.RspValid != 4'b0000), 32'd1);
            end
        end
    end

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_iss.size() != 0 || exp_rsp.size() != 0 || bus.Busy) && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check_eq("drain", 32'((exp_iss.size() == 0) && (exp_rsp.size() == 0) && !bus.Busy), 32'd1);
    endtask

    task automatic wait_issues(input int target, input int budget);
        int n = 0;
        while (issue_cnt < target && n < budget) begin
            @(negedge Clk);
            n++;
        end
        check_eq("issue_count", 32'(issue_cnt >= target), 32'd1);
    endtask

    task automatic set_data_index();
        for (int i = 0; i < NREQ; i++) bus.ReqData[16*i +: 16] = 16'hC000 | 16'(i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int raise_cyc;
        int n;
        bus.Req = 4'b0000;
        bus.ReqData = '0;
        bus.LinkInterrupt = 1'b0;
        bus.IrqClear = 1'b0;
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        check_eq("rst_busy", 32'(bus.Busy), 32'd0);
        check_eq("rst_ack", 32'(bus.ReqAck), 32'd0);
        check_eq("rst_valid", 32'(bus.RspValid), 32'd0);
        check_eq("rst_raise", 32'(bus.LinkRaise), 32'd0);
        check_eq("rst_dout", 32'(bus.LinkDout), 32'd0);
        check_eq("rst_data", 32'(bus.RspData), 32'd0);
        check_eq("rst_err", 32'(bus.RspErr), 32'd0);
        check_eq("rst_irq", 32'(bus.IrqPending), 32'd0);
        Reset = 1'b0;
        @(negedge Clk);

        // Basic transaction with latency checks
        tgt_en = 1'b1; tgt_fixed = 1'b1; tgt_val = 16'hBEEF; tgt_delay = 1;
        push_iss(4'd0, 16'h1234);
        push_rsp(4'd0, 16'hBEEF, 1'b0);
        bus.ReqData[15:0] = 16'h1234;
        bus.Req = 4'b0001;
        @(negedge Clk);
        check_eq("t1_raise", 32'(bus.LinkRaise), 32'd1);
        check_eq("t1_ack", 32'(bus.ReqAck), 32'd1);
        check_eq("t1_busy", 32'(bus.Busy), 32'd1);
        bus.Req = 4'b0000;
        @(negedge Clk);
        check_eq("t1_raise_once", 32'(bus.LinkRaise), 32'd0);
        wait_done(50);
        check_eq("t1_dout_hold", 32'(bus.LinkDout), 32'h1234);

        // All requesters: order 0,1,2,3,0 from reset pointer, issues 4 cycles apart
        Reset = 1'b1; @(negedge Clk); Reset = 1'b0;
        set_data_index();
        tgt_fixed = 1'b0; tgt_delay = 0;
        for (int k = 0; k < 5; k++) begin
            push_iss(4'(k % 4), 16'hC000 | 16'(k % 4));
            push_rsp(4'(k % 4), 16'(k % 4), 1'b0);
        end
        last_raise = -1; chk_spacing = 1'b1;
        base = issue_cnt;
        bus.Req = 4'b1111;
        wait_issues(base + 5, 60);
        bus.Req = 4'b0000;
        wait_done(50);
        chk_spacing = 1'b0;

        // Single requester held: re-granted every time
        for (int k = 0; k < 3; k++) begin
            push_iss(4'd2, 16'hC002);
            push_rsp(4'd2, 16'h0002, 1'b0);
        end
        base = issue_cnt;
        bus.Req = 4'b0100;
        wait_issues(base + 3, 60);
        bus.Req = 4'b0000;
        wait_done(50);

        // Stray strobe in IDLE
        tgt_en = 1'b0;
        bus.LinkDin = 16'hDEAD; bus.LinkStrobe = 1'b1;
        @(negedge Clk);
        bus.LinkStrobe = 1'b0;
        check_eq("stray_idle_valid", 32'(bus.RspValid), 32'd0);
        check_eq("stray_idle_busy", 32'(bus.Busy), 32'd0);
        check_eq("stray_idle_data", 32'(bus.RspData), 32'(last_data));

        // Stray strobe in ISSUE, then a late genuine strobe
        push_iss(4'd1, 16'h7777);
        bus.ReqData[31:16] = 16'h7777;
        bus.Req = 4'b0010;
        @(negedge Clk);
        bus.Req = 4'b0000;
        bus.LinkDin = 16'hDEAD; bus.LinkStrobe = 1'b1;
        @(negedge Clk);
        bus.LinkStrobe = 1'b0;
        check_eq("stray_issue_valid", 32'(bus.RspValid), 32'd0);
        check_eq("stray_issue_busy", 32'(bus.Busy), 32'd1);
        check_eq("stray_issue_data", 32'(bus.RspData), 32'(last_data));
`ifdef RETROCOMM_ARB_TIMEOUT_EN
        repeat (3) @(negedge Clk);
`else
        repeat (20) @(negedge Clk);
`endif
        check_eq("wait_holds", 32'(bus.Busy), 32'd1);
        push_rsp(4'd1, 16'h4321, 1'b0);
        bus.LinkDin = 16'h4321; bus.LinkStrobe = 1'b1;
        @(negedge Clk);
        bus.LinkStrobe = 1'b0;
        check_eq("late_rsp_valid", 32'(bus.RspValid), 32'h2);
        wait_done(20);

`ifdef RETROCOMM_ARB_TIMEOUT_EN
        // No strobe: error completion; decision on the TMO-th WAIT cycle
        push_iss(4'd0, 16'hAAAA);
        push_rsp(4'd0, 16'hFFFF, 1'b1);
        bus.ReqData[15:0] = 16'hAAAA;
        bus.Req = 4'b0001;
        @(negedge Clk);
        bus.Req = 4'b0000;
        raise_cyc = cyc;
        n = 0;
        while (bus.RspValid == 4'b0000 && n < 40) begin @(negedge Clk); n++; end
        check_eq("tmo_lat", cyc - raise_cyc, TMO + 1);
        wait_done(20);

        // Strobe in the expiry cycle wins
        tgt_en = 1'b1; tgt_fixed = 1'b1; tgt_val = 16'h5555; tgt_delay = TMO - 1;
        push_iss(4'd1, 16'hBBBB);
        push_rsp(4'd1, 16'h5555, 1'b0);
        bus.ReqData[31:16] = 16'hBBBB;
        bus.Req = 4'b0010;
        @(negedge Clk);
        bus.Req = 4'b0000;
        raise_cyc = cyc;
        n = 0;
        while (bus.RspValid == 4'b0000 && n < 40) begin @(negedge Clk); n++; end
        check_eq("tmo_edge_lat", cyc - raise_cyc, TMO + 1);
        wait_done(20);
        tgt_en = 1'b0;
`else
        raise_cyc = 0;
        n = 0;
`endif

        // Interrupt edge detect, sticky, set-wins
        bus.LinkInterrupt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            check_eq("irq_held", 32'(bus.IrqPending), 32'd1);
        end
        bus.IrqClear = 1'b1;
        @(negedge Clk);
        bus.IrqClear = 1'b0;
        check_eq("irq_clear_level", 32'(bus.IrqPending), 32'd0);
        @(negedge Clk);
        check_eq("irq_no_reset_level", 32'(bus.IrqPending), 32'd0);
        bus.LinkInterrupt = 1'b0;
        @(negedge Clk);
        bus.LinkInterrupt = 1'b1; bus.IrqClear = 1'b1;
        @(negedge Clk);
        check_eq("irq_set_wins", 32'(bus.IrqPending), 32'd1);
        bus.LinkInterrupt = 1'b0;
        @(negedge Clk);
        bus.IrqClear = 1'b0;
        check_eq("irq_clear", 32'(bus.IrqPending), 32'd0);

        // Reset during WAIT, then pointer restarts at requester 0
        push_iss(4'd2, 16'h1111);
        bus.ReqData[47:32] = 16'h1111;
        bus.Req = 4'b0100;
        @(negedge Clk);
        bus.Req = 4'b0000;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("rstw_busy", 32'(bus.Busy), 32'd0);
        check_eq("rstw_valid", 32'(bus.RspValid), 32'd0);
        check_eq("rstw_dout", 32'(bus.LinkDout), 32'd0);
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        check_eq("rstw_no_rsp", 32'(bus.Busy), 32'd0);
        set_data_index();
        tgt_en = 1'b1; tgt_fixed = 1'b0; tgt_delay = 0;
        for (int k = 0; k < 3; k++) begin
            push_iss(4'(k), 16'hC000 | 16'(k));
            push_rsp(4'(k), 16'(k), 1'b0);
        end
        base = issue_cnt;
        bus.Req = 4'b1111;
        wait_issues(base + 3, 60);
        bus.Req = 4'b0000;
        wait_done(50);

        check_eq("queues_empty", 32'(exp_iss.size() + exp_rsp.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
